// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch port and the data port of the pipelined core. Each access
// runs IDLE -> ISSUE -> WAIT -> RESP. Data has priority over fetch, but fetch is
// forced after STARVE_LIMIT consecutive data grants taken while it was waiting.
// A fetch squashed by if_flush still completes at the memory, silently.
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 3,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_fetch_q, gnt_fetch_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            squash_q, squash_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            fetch_win;
  logic            squashed;

  // A flush in the current cycle counts as well as one already recorded.
  assign squashed = squash_q | if_flush;

  // Next-state logic: arbitration in IDLE, latency countdown in WAIT.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    gnt_fetch_d = gnt_fetch_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    squash_d    = squash_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_win   = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          fetch_win   = if_req && (!d_req || (starve_q == SW'(STARVE_LIMIT)));
          gnt_fetch_d = fetch_win;
          we_d        = fetch_win ? 1'b0 : d_we;
          addr_d      = fetch_win ? if_addr : d_addr;
          wdata_d     = fetch_win ? '0 : d_wdata;
          // Count data grants that made a waiting fetch wait again.
          if (!fetch_win && if_req) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
          squash_d = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = CW'(LATENCY - 1);
        state_d = WAIT;
        if (gnt_fetch_q && if_flush) squash_d = 1'b1;
      end
      WAIT: begin
        if (gnt_fetch_q && if_flush) squash_d = 1'b1;
        if (wait_q == '0) begin
          // mem_rdata is valid exactly LATENCY cycles after the ISSUE cycle.
          if (gnt_fetch_q) begin
            if (!squashed) if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      RESP: begin
        if (gnt_fetch_q && if_flush) squash_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the rdata registers are reset because they drive output pins; the
      // request latches are reset too so a reset leaves no stale transaction behind.
      state_q     <= IDLE;
      gnt_fetch_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
      squash_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= state_d;
      gnt_fetch_q <= gnt_fetch_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      squash_q    <= squash_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Outputs decoded from state; memory pins are zero outside ISSUE.
  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    if_ready  = (state_q == RESP) && gnt_fetch_q && !squashed;
    d_ready   = (state_q == RESP) && !gnt_fetch_q;
    busy      = (state_q != IDLE);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int L   = 2;
  localparam int LIM = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.LATENCY(L), .STARVE_LIMIT(LIM), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second instance built with LATENCY=1.
  logic        d_req1;
  logic [31:0] d_addr1, mem_rdata1;
  logic        if_ready1, d_ready1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(LIM), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_flush(1'b0),
    .if_ready(if_ready1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata(32'h0),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Environment memory: answers the DUT's pins with fixed latency, junk otherwise.
  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];
  int          tcyc  = 0;
  int          rd_due = -1;
  logic [31:0] rd_data;

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
      else begin
        rd_due  = tcyc + L;
        rd_data = env_mem[mem_addr[7:2]];
      end
    end
  end

  always @(posedge clk) begin
    tcyc = tcyc + 1;
    #1;
    mem_rdata = (tcyc == rd_due) ? rd_data : $urandom;
  end

  // Reference model: p is the position inside an access (0 = idle, 1 = issue,
  // L+2 = response); the grant is decided from the request rules alone.
  int          p = 0;
  int          starve = 0;
  bit          mg_f, mg_we, sq;
  logic [31:0] mg_addr, mg_wdata;
  logic [31:0] exp_ifr = '0, exp_dr = '0;
  logic        o_ifr, o_dr, o_busy;

  // One clock cycle: inputs are already set; check at negedge, then advance the model.
  task automatic cyc();
    logic e_resp, e_issue, e_ifr, e_dr;
    e_issue = (p == 1);
    e_resp  = (p == L + 2);
    e_ifr   = e_resp && mg_f && !(sq || if_flush);
    e_dr    = e_resp && !mg_f;
    if (e_resp && mg_f && !sq)         exp_ifr = ref_mem[mg_addr[7:2]];
    if (e_resp && !mg_f && !mg_we)     exp_dr  = ref_mem[mg_addr[7:2]];
    @(negedge clk);
    check("busy",      32'(busy),     32'(p != 0));
    check("mem_en",    32'(mem_en),   32'(e_issue));
    check("mem_we",    32'(mem_we),   32'(e_issue && mg_we));
    check("mem_addr",  mem_addr,      e_issue ? mg_addr : 32'h0);
    check("mem_wdata", mem_wdata,     e_issue ? mg_wdata : 32'h0);
    check("if_ready",  32'(if_ready), 32'(e_ifr));
    check("d_ready",   32'(d_ready),  32'(e_dr));
    check("if_rdata",  if_rdata,      exp_ifr);
    check("d_rdata",   d_rdata,       exp_dr);
    o_ifr  = if_ready;
    o_dr   = d_ready;
    o_busy = busy;
    if (rst) begin
      p = 0; starve = 0; sq = 0; exp_ifr = '0; exp_dr = '0;
    end else if (p == 0) begin
      if (if_req || d_req) begin
        mg_f = if_req && (!d_req || starve == LIM);
        if (!mg_f && if_req) starve = (starve < LIM) ? starve + 1 : LIM;
        else starve = 0;
        mg_we    = mg_f ? 1'b0 : d_we;
        mg_addr  = mg_f ? if_addr : d_addr;
        mg_wdata = mg_f ? 32'h0 : d_wdata;
        if (mg_we) ref_mem[mg_addr[7:2]] = mg_wdata;
        sq = 0;
        p  = 1;
      end
    end else begin
      if (mg_f && if_flush) sq = 1;
      p = (p == L + 2) ? 0 : p + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [5:0] idx;
    idx = 6'($urandom);
    return {24'h0, idx, 2'b00};
  endfunction

  initial begin
    int          rdy_at, n, n_ready;
    bit          seen, pf, busy5;
    logic [7:0]  order;
    rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    d_req1 = 0; d_addr1 = '0; mem_rdata1 = '0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'h8C020004;
    ref_mem[4] = 32'h8C020004;

    // Reset state.
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;

    // Single fetch from 0x10.
    if_req = 1; if_addr = 32'h10; rdy_at = -1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (o_ifr) begin rdy_at = k; if_req = 0; end
    end
    check("fetch_ready_cycle", 32'(rdy_at), 32'd4);
    check("fetch_rdata", if_rdata, 32'h8C020004);

    // Data write.
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; rdy_at = -1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (o_dr) begin rdy_at = k; d_req = 0; end
    end
    d_we = 0;
    check("write_ready_cycle", 32'(rdy_at), 32'd4);
    check("write_d_rdata_kept", d_rdata, 32'h0);
    check("write_mem_contents", env_mem[8], 32'hDEADBEEF);

    // Both requesters held continuously: D,D,D,F,D,D,D,F.
    if_req = 1; if_addr = 32'h30; d_req = 1; d_addr = 32'h40;
    order = '0; n = 0;
    for (int k = 0; k < 80 && n < 8; k++) begin
      cyc();
      if (o_ifr || o_dr) begin order = {order[6:0], o_ifr}; n++; end
    end
    if_req = 0; d_req = 0;
    check("starve_grants", 32'(n), 32'd8);
    check("starve_order", 32'(order), 32'h11);

    // Fetch flushed during WAIT.
    check("flush_old_rdata", if_rdata, ref_mem[12]);
    if_req = 1; if_addr = 32'h50; seen = 0; busy5 = 1;
    for (int k = 0; k < 6; k++) begin
      if_flush = (k == 2);
      cyc();
      if (o_ifr) seen = 1;
      if (k == 2) if_req = 0;
      if (k == 5) busy5 = o_busy;
    end
    if_flush = 0;
    check("flush_no_ready", 32'(seen), 32'd0);
    check("flush_rdata_kept", if_rdata, ref_mem[12]);
    check("flush_idle_cycle5", 32'(busy5), 32'd0);

    // Reset during WAIT of a data read, request held through it.
    d_req = 1; d_we = 0; d_addr = 32'h60; rdy_at = -1;
    for (int k = 0; k < 10; k++) begin
      rst = (k == 2);
      cyc();
      if (o_dr && rdy_at < 0) begin rdy_at = k; d_req = 0; end
    end
    rst = 0;
    check("reset_then_ready_cycle", 32'(rdy_at), 32'd7);
    check("reset_then_rdata", d_rdata, ref_mem[24]);

    // Random traffic against the model.
    n_ready = 0;
    for (int n2 = 0; n2 < 600; n2++) begin
      pf = if_flush;
      if_flush = ($urandom_range(0, 9) == 0);
      if (if_req && (o_ifr || pf)) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (d_req && o_dr) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = rand_addr(); d_wdata = $urandom;
      end
      cyc();
      if (o_ifr || o_dr) n_ready++;
    end
    check("random_progress", 32'(n_ready > 50), 32'd1);
    if_req = 0; d_req = 0; if_flush = 0;

    // LATENCY=1 instance: data read returning 7.
    d_req1 = 1; d_addr1 = 32'h40; rdy_at = -1;
    for (int k = 0; k < 6; k++) begin
      mem_rdata1 = (k == 2) ? 32'h7 : 32'hFFFF_FFFF;
      @(negedge clk);
      if (k == 1) begin
        check("lat1_mem_en", 32'(mem_en1), 32'd1);
        check("lat1_mem_addr", mem_addr1, 32'h40);
      end
      if (d_ready1 && rdy_at < 0) rdy_at = k;
      @(posedge clk); #1;
      if (rdy_at >= 0) d_req1 = 0;
    end
    check("lat1_ready_cycle", 32'(rdy_at), 32'd3);
    check("lat1_rdata", d_rdata1, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the instruction-fetch port and the data-memory port of the pipelined MIPS core onto one shared single-ported memory with fixed read latency.
- Sequences each access as issue, wait, capture, respond, and returns a one-cycle ready pulse to the winning requester.
- The pipeline uses a low ready as a stall: PCWrite/IF_ID_Write for fetch, a MEM-stage hold for data.
- Data has priority over fetch, with a bounded anti-starvation rule. A fetch squashed by IF_Flush still completes on the memory side but never returns a response.

Parameters:
- LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata (>=1).
- STARVE_LIMIT, 3, consecutive data grants with a fetch pending before fetch is forced (>=1).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready, or dropped after flush.
- if_addr  in  AW  fetch address (PCResult).
- if_flush  in  1  IF_Flush; squashes an in-flight fetch response.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ready  out  1  one-cycle pulse: access complete, d_rdata valid for reads.
- d_rdata  out  DW  read data.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LATENCY cycles after mem_en.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All outputs 0, including if_rdata and d_rdata.
  - Wait counter = 0, starvation counter = 0, squash flag = 0.
- Reset mid-transaction: abandon the transaction; no ready pulse is ever produced for it.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample requests. With none, stay in IDLE.
  - Otherwise latch the grant (fetch or data) plus the address, we and wdata, then go to ISSUE.
- Grant rule when both requests are high:
  - Data wins unless starve_cnt == STARVE_LIMIT; in that case fetch wins.
  - A data grant taken while if_req is high increments starve_cnt, saturating at STARVE_LIMIT.
  - A fetch grant, or a data grant with if_req low, clears starve_cnt.
- ISSUE (one cycle):
  - mem_en = 1, with mem_we/mem_addr/mem_wdata driven from the latched request.
  - mem_we = 0 for fetch. Load the wait counter with LATENCY-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reads 0 (issue cycle + LATENCY), mem_rdata is valid. Capture it into the granted requester's rdata register, then go to RESP.
- RESP (one cycle):
  - Pulse the granted requester's ready for one cycle, then go to IDLE.
  - rdata holds its value until the next capture.
  - d_ready also pulses for writes; d_rdata is unchanged on a write.
- Latency: a request sampled in IDLE in cycle 0 gives ISSUE in cycle 1 and ready in cycle LATENCY+2.
- Throughput: one access per LATENCY+3 cycles. RESP always returns to IDLE, so a requester dropping req after its ready is never double-served.
- Flush:
  - if_flush high in any cycle from ISSUE through RESP of a fetch grant sets the squash flag.
  - When the squash flag is set, RESP does not assert if_ready and does not update if_rdata. The memory transaction still runs to completion.
  - if_flush in IDLE has no effect; arbitration uses if_req alone.
  - if_flush never affects a data grant.
- Requests arriving while busy are ignored until IDLE; requesters hold them.
- if_ready and d_ready are never high in the same cycle.

Test Plan:
- Reset, then a single fetch with LATENCY=2, if_addr=0x10, mem returning 0x8C020004 → mem_en in cycle 1 with mem_addr=0x10 and mem_we=0; if_ready in cycle 4 with if_rdata=0x8C020004; busy low in cycle 5.
- d_req with d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_en=mem_we=1 with address 0x20 and that data in the issue cycle; d_ready pulses 3 cycles later; d_rdata unchanged.
- if_req and d_req both held continuously, STARVE_LIMIT=3 → grant order D,D,D,F,D,D,D,F; no ready pulses overlap.
- Fetch issued with if_flush pulsed in its WAIT cycle → mem transaction completes; if_ready stays 0; if_rdata keeps its old value; FSM back in IDLE at cycle 5.
- rst asserted during WAIT of a data read → next cycle state IDLE, all outputs 0, no d_ready pulse; a new request afterwards completes normally.
- LATENCY=1 build, data read with mem returning 0x00000007 → ready in cycle 3 with d_rdata=0x7.
